// File: rtl/systolic_out_deskew.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_out_deskew
//  Purpose  : Realigns skewed per-column partial sums from the bottom row of
//             the PE array into whole row vectors. Each column has its own FIFO
//             to absorb the skew and any backpressure. Rows are presented on
//             one valid/ready handshake, and overflow is reported as a sticky flag.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_out_deskew #(
  parameter int PE_ARRAY_W     = 4,
  parameter int OUT_DATA_WIDTH = 24,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic [PE_ARRAY_W-1:0]     i_col_vld,
  input  logic [OUT_DATA_WIDTH-1:0] i_col_data [PE_ARRAY_W],
  output logic                      o_row_vld,
  input  logic                      i_row_rdy,
  output logic [OUT_DATA_WIDTH-1:0] o_row_data [PE_ARRAY_W],
  output logic                      o_ovf,
  output logic [CNT_WIDTH-1:0]      o_row_cnt,
  output logic                      o_busy
);

  localparam int              c_PW    = $clog2(FIFO_DEPTH);
  localparam logic [c_PW:0]   c_DEPTH = (c_PW+1)'(FIFO_DEPTH);
  localparam logic [c_PW:0]   c_LAST  = (c_PW+1)'(FIFO_DEPTH - 1);

  logic [PE_ARRAY_W-1:0] w_empty;
  logic [PE_ARRAY_W-1:0] w_full;
  logic [PE_ARRAY_W-1:0] w_ovf_ev;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  r_row_cnt;
  logic                  r_ovf;

  // Pointers count 0..FIFO_DEPTH-1 and wrap explicitly.
  function automatic logic [c_PW:0] f_inc(input logic [c_PW:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // A row exists only when every lane has a head word; all lanes pop together.
  assign o_row_vld = ~|w_empty;
  assign w_pop     = o_row_vld & i_row_rdy;
  assign o_busy    = ~&w_empty;
  assign o_ovf     = r_ovf;
  assign o_row_cnt = r_row_cnt;

  for (genvar j = 0; j < PE_ARRAY_W; j++) begin : g_col
    logic [c_PW:0]             r_wptr;
    logic [c_PW:0]             r_rptr;
    logic [c_PW:0]             r_occ;
    logic [OUT_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                      w_wr;

    assign w_full[j]     = (r_occ == c_DEPTH);
    assign w_empty[j]    = (r_occ == '0);
    // A full FIFO still accepts a word when the row pop frees a slot in the same cycle.
    assign w_wr          = i_col_vld[j] & (~w_full[j] | w_pop);
    assign w_ovf_ev[j]   = i_col_vld[j] & w_full[j] & ~w_pop;
    assign o_row_data[j] = r_mem[r_rptr[c_PW-1:0]];

    // Pointer and occupancy tracking; a flush discards that cycle's traffic.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else if (i_clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else begin
        if (w_wr)  r_wptr <= f_inc(r_wptr);
        if (w_pop) r_rptr <= f_inc(r_rptr);
        case ({w_wr, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end

    // Word storage needs no reset; the head is only meaningful when occupancy is non-zero.
    always_ff @(posedge clk) begin
      if (w_wr && !i_clr) r_mem[r_wptr[c_PW-1:0]] <= i_col_data[j];
    end
  end

  // Emitted-row counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (i_clr) begin
      r_row_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_pop)     r_row_cnt <= r_row_cnt + 1'b1;
      if (|w_ovf_ev) r_ovf     <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_out_deskew.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_out_deskew
//  Purpose  : Directed bench for systolic_out_deskew with a row scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_out_deskew;

  logic        clk;
  logic        rst;
  logic        i_clr;
  logic [3:0]  i_col_vld;
  logic [23:0] i_col_data [4];
  logic        o_row_vld;
  logic        i_row_rdy;
  logic [23:0] o_row_data [4];
  logic        o_ovf;
  logic [15:0] o_row_cnt;
  logic        o_busy;

  int n_cmp;
  int n_fail;
  int exp_cnt;
  logic [127:0] exp_q [$];
  bit  popped;

  systolic_out_deskew #(
    .PE_ARRAY_W(4), .OUT_DATA_WIDTH(24), .FIFO_DEPTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_col_vld(i_col_vld),
    .i_col_data(i_col_data), .o_row_vld(o_row_vld), .i_row_rdy(i_row_rdy),
    .o_row_data(o_row_data), .o_ovf(o_ovf), .o_row_cnt(o_row_cnt), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [23:0] a0, a1, a2, a3);
    return {32'b0, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cols(input logic [3:0] vld, input logic [23:0] d0, d1, d2, d3);
    i_col_vld     = vld;
    i_col_data[0] = d0;
    i_col_data[1] = d1;
    i_col_data[2] = d2;
    i_col_data[3] = d3;
  endtask

  // Drive all four columns with one aligned row and record it as expected.
  task automatic drive_row(input logic [23:0] base);
    set_cols(4'hF, base, base + 24'd1, base + 24'd2, base + 24'd3);
    exp_q.push_back(pack4(base, base + 24'd1, base + 24'd2, base + 24'd3));
  endtask

  // One clock: sample before the edge, score a pop if the handshake fires, advance.
  task automatic cycle();
    #1;
    popped = 1'b0;
    if (o_row_vld && i_row_rdy && !i_clr && rst) begin
      popped = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_row", pack4(o_row_data[0], o_row_data[1], o_row_data[2], o_row_data[3]), 128'h0);
        n_fail += (n_fail == 0) ? 0 : 0;
      end else begin
        chk("row_data", pack4(o_row_data[0], o_row_data[1], o_row_data[2], o_row_data[3]),
            exp_q.pop_front());
      end
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    i_row_rdy = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      cycle();
      budget++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'h0);
  endtask

  initial begin
    int first_pop;
    int last_pop;
    logic [127:0] head0;
    n_cmp = 0; n_fail = 0; exp_cnt = 0;
    rst = 1'b0; i_clr = 1'b0; i_row_rdy = 1'b0;
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);

    // Reset state
    #2;
    chk("rst_row_vld", 128'(o_row_vld), 128'h0);
    chk("rst_ovf", 128'(o_ovf), 128'h0);
    chk("rst_cnt", 128'(o_row_cnt), 128'h0);
    chk("rst_busy", 128'(o_busy), 128'h0);
    #6 rst = 1'b1;
    @(posedge clk);
    #1;

    // Skewed stream: column j presents 100*j+k starting at cycle j
    i_row_rdy = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(pack4(24'(k), 24'(100 + k), 24'(200 + k), 24'(300 + k)));
    first_pop = -1; last_pop = -1;
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < 4; j++) begin
        i_col_vld[j]  = (c - j >= 0) && (c - j < 4);
        i_col_data[j] = i_col_vld[j] ? 24'(100 * j + c - j) : 24'h0;
      end
      if (c == 1) begin
        #1;
        chk("busy_after_first_write", 128'(o_busy), 128'h1);
        #(-0);
      end
      cycle();
      if (popped) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
    end
    chk("skew_first_pop_cycle", 128'(first_pop), 128'd4);
    chk("skew_last_pop_cycle", 128'(last_pop), 128'd7);
    chk("skew_cnt", 128'(o_row_cnt), 128'd4);
    chk("skew_ovf", 128'(o_ovf), 128'h0);
    chk("skew_left", 128'(exp_q.size()), 128'h0);

    // Backpressure: 8 aligned rows with the consumer stalled
    i_row_rdy = 1'b0;
    for (int r = 0; r < 8; r++) begin
      drive_row(24'(1000 + 16 * r));
      cycle();
    end
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    head0 = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_row_vld", 128'(o_row_vld), 128'h1);
      chk("bp_hold", pack4(o_row_data[0], o_row_data[1], o_row_data[2], o_row_data[3]), head0);
    end

    // Overflow: a 9th word into column 2 only while stalled
    set_cols(4'b0100, 24'h0, 24'h0, 24'hDEAD, 24'h0);
    cycle();
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    chk("ovf_set", 128'(o_ovf), 128'h1);
    drain();
    chk("ovf_no_9th_vld", 128'(o_row_vld), 128'h0);
    chk("bp_busy_after", 128'(o_busy), 128'h0);
    chk("bp_cnt", 128'(o_row_cnt), 128'(16'(exp_cnt)));

    // Clear versus write in the same cycle
    i_clr = 1'b1;
    set_cols(4'hF, 24'h1, 24'h2, 24'h3, 24'h4);
    cycle();
    i_clr = 1'b0;
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    exp_cnt = 0;
    chk("clr_busy", 128'(o_busy), 128'h0);
    chk("clr_cnt", 128'(o_row_cnt), 128'h0);
    chk("clr_ovf", 128'(o_ovf), 128'h0);
    chk("clr_row_vld", 128'(o_row_vld), 128'h0);

    // Full FIFOs, simultaneous pop and write in every column
    i_row_rdy = 1'b0;
    for (int r = 0; r < 8; r++) begin
      drive_row(24'(2000 + 16 * r));
      cycle();
    end
    i_row_rdy = 1'b1;
    drive_row(24'd3000);
    cycle();
    chk("fullpop_popped", 128'(popped), 128'h1);
    i_row_rdy = 1'b0;
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    chk("fullpop_ovf", 128'(o_ovf), 128'h0);
    chk("fullpop_cnt", 128'(o_row_cnt), 128'd1);
    drain();
    chk("fullpop_empty_after_8", 128'(o_row_vld), 128'h0);
    chk("fullpop_cnt_after", 128'(o_row_cnt), 128'd9);

    // Asynchronous reset between edges with 3 rows buffered
    i_row_rdy = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive_row(24'(4000 + 16 * r));
      cycle();
    end
    set_cols(4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    chk("pre_rst_row_vld", 128'(o_row_vld), 128'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_row_vld", 128'(o_row_vld), 128'h0);
    chk("arst_cnt", 128'(o_row_cnt), 128'h0);
    chk("arst_busy", 128'(o_busy), 128'h0);
    exp_q.delete();
    exp_cnt = 0;
    #2 rst = 1'b1;

    // Counter wrap: 65537 rows through at full rate
    i_row_rdy = 1'b1;
    for (int r = 0; r < 65537; r++) begin
      drive_row(24'(r * 4));
      cycle();
    end
    drain();
    chk("wrap_model_rows", 128'(exp_cnt), 128'd65537);
    chk("wrap_cnt", 128'(o_row_cnt), 128'd1);
    chk("wrap_ovf", 128'(o_ovf), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
